// File: rtl/pf_lanectrl_dly_seq.sv
// rtl/pf_lanectrl_dly_seq.sv - DQS delay-line tap sequencer for one DDR4 lane controller
//
// Runs in the FAB_CLK domain. Accepts a move or reload command for the RX or
// TX DQS delay line and wraps it in an HS_IO_CLK_PAUSE window. Inside that
// window it issues spaced single-cycle MOVE/LOAD pulses, tracks both tap
// positions and aborts on lane out-of-range or tap saturation.
//
// Ports:
//   FAB_CLK, RESET_N               clock, synchronous active-low reset
//   CMD_VALID/CMD_READY            command handshake (READY only in IDLE)
//   CMD_SEL/CMD_DIR/CMD_LOAD       line select, direction, reload request
//   CMD_COUNT                      taps to move
//   RX/TX_DELAY_LINE_OUT_OF_RANGE  lane range flags
//   DELAY_LINE_SEL/_DIRECTION      registered controls, stable for the window
//   DELAY_LINE_MOVE/_LOAD          single-cycle pulses to the lane
//   HS_IO_CLK_PAUSE                pause request to the lane
//   RX_TAP, TX_TAP                 tracked tap positions
//   DONE, OOR, MOVED               completion pulse, abort flag, taps moved

module pf_lanectrl_dly_seq #(
    parameter int unsigned TAP_MAX     = 255,
    parameter int unsigned INIT_TAP    = 1,
    parameter int unsigned PAUSE_LEAD  = 2,
    parameter int unsigned MOVE_GAP    = 4,
    parameter int unsigned PAUSE_TRAIL = 2
) (
    input  logic       FAB_CLK,
    input  logic       RESET_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_SEL,
    input  logic       CMD_DIR,
    input  logic       CMD_LOAD,
    input  logic [7:0] CMD_COUNT,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_LOAD,
    output logic       HS_IO_CLK_PAUSE,
    output logic [7:0] RX_TAP,
    output logic [7:0] TX_TAP,
    output logic       DONE,
    output logic       OOR,
    output logic [7:0] MOVED
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_PULSE, S_GAP, S_TRAIL, S_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] moved_q, moved_d;
    logic [7:0] rx_tap_q, rx_tap_d;
    logic [7:0] tx_tap_q, tx_tap_d;
    logic       sel_q, sel_d;
    logic       dir_q, dir_d;
    logic       load_q, load_d;
    logic       oor_q, oor_d;

    logic [7:0] cur_tap;
    logic       sat;
    logic       lane_oor;

    assign cur_tap  = sel_q ? tx_tap_q : rx_tap_q;
    // A move that would step past either end of the line is refused outright.
    assign sat      = dir_q ? (cur_tap == 8'(TAP_MAX)) : (cur_tap == 8'd0);
    assign lane_oor = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            moved_q  <= '0;
            rx_tap_q <= 8'(INIT_TAP);
            tx_tap_q <= 8'(INIT_TAP);
            sel_q    <= 1'b0;
            dir_q    <= 1'b0;
            load_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            moved_q  <= moved_d;
            rx_tap_q <= rx_tap_d;
            tx_tap_q <= tx_tap_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            load_q   <= load_d;
            oor_q    <= oor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        moved_d  = moved_q;
        rx_tap_d = rx_tap_q;
        tx_tap_d = tx_tap_q;
        sel_d    = sel_q;
        dir_d    = dir_q;
        load_d   = load_q;
        oor_d    = oor_q;

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    sel_d   = CMD_SEL;
                    dir_d   = CMD_DIR;
                    load_d  = CMD_LOAD;
                    rem_d   = CMD_COUNT;
                    moved_d = '0;
                    oor_d   = 1'b0;
                    cnt_d   = 8'(PAUSE_LEAD - 1);
                    state_d = S_LEAD;
                end
            end
            S_LEAD: begin
                if (cnt_q == 8'd0) begin
                    if (load_q || rem_q != 8'd0) begin
                        state_d = S_PULSE;
                    end else begin
                        cnt_d   = 8'(PAUSE_TRAIL - 1);
                        state_d = S_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PULSE: begin
                if (load_q) begin
                    if (sel_q) tx_tap_d = 8'(INIT_TAP);
                    else       rx_tap_d = 8'(INIT_TAP);
                    // Zero remaining so the gap ends in TRAIL.
                    rem_d   = '0;
                    cnt_d   = 8'(MOVE_GAP - 1);
                    state_d = S_GAP;
                end else if (sat) begin
                    oor_d   = 1'b1;
                    cnt_d   = 8'(PAUSE_TRAIL - 1);
                    state_d = S_TRAIL;
                end else begin
                    if (sel_q) tx_tap_d = dir_q ? tx_tap_q + 8'd1 : tx_tap_q - 8'd1;
                    else       rx_tap_d = dir_q ? rx_tap_q + 8'd1 : rx_tap_q - 8'd1;
                    moved_d = moved_q + 8'd1;
                    rem_d   = rem_q - 8'd1;
                    cnt_d   = 8'(MOVE_GAP - 1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (lane_oor) begin
                    oor_d   = 1'b1;
                    cnt_d   = 8'(PAUSE_TRAIL - 1);
                    state_d = S_TRAIL;
                end else if (cnt_q == 8'd0) begin
                    if (rem_q != 8'd0) begin
                        state_d = S_PULSE;
                    end else begin
                        cnt_d   = 8'(PAUSE_TRAIL - 1);
                        state_d = S_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == 8'd0) state_d = S_FIN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CMD_READY            = (state_q == S_IDLE);
    assign HS_IO_CLK_PAUSE      = (state_q == S_LEAD) || (state_q == S_PULSE) ||
                                  (state_q == S_GAP)  || (state_q == S_TRAIL);
    assign DELAY_LINE_MOVE      = (state_q == S_PULSE) && !load_q && !sat;
    assign DELAY_LINE_LOAD      = (state_q == S_PULSE) && load_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DONE                 = (state_q == S_FIN);
    assign OOR                  = oor_q;
    assign MOVED                = moved_q;
    assign RX_TAP               = rx_tap_q;
    assign TX_TAP               = tx_tap_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// tb/tb_pf_lanectrl_dly_seq.sv - self-checking bench for pf_lanectrl_dly_seq

module tb_pf_lanectrl_dly_seq;

    localparam int TAP_MAX     = 255;
    localparam int INIT_TAP    = 1;
    localparam int PAUSE_LEAD  = 2;
    localparam int MOVE_GAP    = 4;
    localparam int PAUSE_TRAIL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_sel, cmd_dir, cmd_load;
    logic [7:0] cmd_count;
    logic       rx_oor, tx_oor;
    logic       cmd_ready, dl_sel, dl_dir, dl_move, dl_load, pause, done, oor;
    logic [7:0] rx_tap, tx_tap, moved;

    int n_checks = 0;
    int n_errors = 0;
    int rx_t = INIT_TAP;
    int tx_t = INIT_TAP;

    always #5 clk = ~clk;

    pf_lanectrl_dly_seq #(
        .TAP_MAX(TAP_MAX), .INIT_TAP(INIT_TAP), .PAUSE_LEAD(PAUSE_LEAD),
        .MOVE_GAP(MOVE_GAP), .PAUSE_TRAIL(PAUSE_TRAIL)
    ) dut (
        .FAB_CLK(clk), .RESET_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_SEL(cmd_sel),
        .CMD_DIR(cmd_dir), .CMD_LOAD(cmd_load), .CMD_COUNT(cmd_count),
        .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor), .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor),
        .DELAY_LINE_SEL(dl_sel), .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_LOAD(dl_load),
        .HS_IO_CLK_PAUSE(pause), .RX_TAP(rx_tap), .TX_TAP(tx_tap),
        .DONE(done), .OOR(oor), .MOVED(moved)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_pause"}, pause, 0);
        check({tag, "_move"},  dl_move, 0);
        check({tag, "_load"},  dl_load, 0);
        check({tag, "_sel"},   dl_sel, 0);
        check({tag, "_dir"},   dl_dir, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_oor"},   oor, 0);
        check({tag, "_moved"}, moved, 0);
        check({tag, "_rxtap"}, rx_tap, INIT_TAP);
        check({tag, "_txtap"}, tx_tap, INIT_TAP);
    endtask

    // Called at #1 after an edge while the DUT is idle. oor_after=k raises the
    // selected line's out-of-range on the first gap cycle after move pulse k.
    task automatic run_cmd(input bit sel, input bit dir, input bit load,
                           input int count, input int oor_after);
        int  exp_pulses[$];
        int  exp_done, exp_moved, exp_load_cyc, t, slot, cyc, done_cyc;
        int  n_move, n_load, last_move, pause_bad, ready_bad, ctrl_bad;
        bit  exp_oor, aborted, injected, in_gap;
        int  got_pulses[$];

        // Reference: walk the command's tap moves at slot granularity.
        t = sel ? tx_t : rx_t;
        exp_moved = 0; exp_oor = 0; aborted = 0; exp_load_cyc = -1;
        if (load) begin
            exp_load_cyc = PAUSE_LEAD + 1;
            exp_done = exp_load_cyc + MOVE_GAP + PAUSE_TRAIL + 1;
            t = INIT_TAP;
        end else begin
            exp_done = PAUSE_LEAD + PAUSE_TRAIL + 1;
            for (int k = 1; k <= count; k++) begin
                slot = PAUSE_LEAD + 1 + (k - 1) * (MOVE_GAP + 1);
                if ((dir && t == TAP_MAX) || (!dir && t == 0)) begin
                    exp_oor = 1; aborted = 1;
                    exp_done = slot + PAUSE_TRAIL + 1;
                    break;
                end
                exp_pulses.push_back(slot);
                t = dir ? t + 1 : t - 1;
                exp_moved++;
                exp_done = slot + MOVE_GAP + PAUSE_TRAIL + 1;
                if (k == oor_after) begin
                    exp_oor = 1; aborted = 1;
                    exp_done = -1;
                    break;
                end
            end
        end

        check("ready_before_cmd", cmd_ready, 1);
        cmd_sel = sel; cmd_dir = dir; cmd_load = load; cmd_count = 8'(count);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_sel = $urandom_range(0, 1); cmd_dir = $urandom_range(0, 1);
        cmd_count = 8'($urandom_range(0, 255));

        n_move = 0; n_load = 0; last_move = -10; done_cyc = -1;
        pause_bad = 0; ready_bad = 0; ctrl_bad = 0; injected = 0;
        for (cyc = 1; cyc <= 4000; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                if (pause) pause_bad++;
                break;
            end
            if (!pause) pause_bad++;
            if (cmd_ready) ready_bad++;
            if (dl_sel !== sel || (!load && dl_dir !== dir)) ctrl_bad++;
            if (dl_move) begin n_move++; last_move = cyc; got_pulses.push_back(cyc); end
            if (dl_load) begin
                n_load++;
                check("load_pulse_cycle", cyc, exp_load_cyc);
            end
            // Gap cycles per the reference timeline; OOR outside them is noise.
            in_gap = 0;
            foreach (exp_pulses[i])
                if (cyc > exp_pulses[i] && cyc <= exp_pulses[i] + MOVE_GAP) in_gap = 1;
            if (exp_load_cyc > 0 && cyc > exp_load_cyc && cyc <= exp_load_cyc + MOVE_GAP) in_gap = 1;
            if (!injected && oor_after != 0 && n_move == oor_after && last_move == cyc - 1) begin
                injected = 1;
                if (sel) tx_oor = 1'b1; else rx_oor = 1'b1;
            end else begin
                if (sel) tx_oor = (!injected && !in_gap) ? 1'($urandom_range(0, 1)) : 1'b0;
                else     rx_oor = (!injected && !in_gap) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (sel) rx_oor = 1'($urandom_range(0, 1));
            else     tx_oor = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rx_oor = 1'b0; tx_oor = 1'b0;

        if (done_cyc < 0) check("done_timeout", 0, 1);
        else if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        check("move_count", n_move, exp_pulses.size());
        foreach (got_pulses[i])
            if (i < exp_pulses.size()) check("move_cycle", got_pulses[i], exp_pulses[i]);
        check("load_count", n_load, load ? 1 : 0);
        check("pause_window", pause_bad, 0);
        check("ready_low_busy", ready_bad, 0);
        check("ctrl_stable", ctrl_bad, 0);
        check("oor_flag", oor, exp_oor);
        check("moved", moved, load ? 0 : exp_moved);
        if (sel) tx_t = t; else rx_t = t;
        check("rx_tap", rx_tap, rx_t);
        check("tx_tap", tx_tap, tx_t);
        @(posedge clk); #1;
        check("ready_after_fin", cmd_ready, 1);
        check("moved_held", moved, load ? 0 : exp_moved);
    endtask

    initial begin
        int cnt, oa;
        bit s, d, l;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_dir = 1'b0;
        cmd_load = 1'b0; cmd_count = '0; rx_oor = 1'b0; tx_oor = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;

        run_cmd(0, 1, 0, 3, 0);     // RX +3 from 1
        run_cmd(1, 1, 0, 0, 0);     // TX count 0
        run_cmd(0, 1, 1, 0, 0);     // RX reload
        run_cmd(0, 0, 0, 5, 0);     // RX -5 from 1: saturates at 0
        run_cmd(1, 1, 0, 10, 2);    // TX +10, lane OOR after pulse 2
        run_cmd(1, 1, 0, 37, 0);    // TX to 40
        run_cmd(1, 0, 1, 9, 0);     // TX reload from 40
        run_cmd(1, 1, 0, 255, 0);   // TX up to TAP_MAX then saturate

        for (int n = 0; n < 30; n++) begin
            s = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 5) == 0);
            cnt = $urandom_range(0, 6);
            oa = (!l && cnt > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, cnt) : 0;
            run_cmd(s, d, l, cnt, oa);
        end

        // Reset in the middle of a move: pause and pulses must drop at once.
        check("ready_before_rst_cmd", cmd_ready, 1);
        cmd_sel = 1'b0; cmd_dir = 1'b1; cmd_load = 1'b0; cmd_count = 8'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midcmd_pause_c9", pause, 1);
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midrst");
        @(posedge clk); #1;
        check("rst_ignores_cmd", pause, 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", cmd_ready, 1);
        rx_t = INIT_TAP; tx_t = INIT_TAP;
        run_cmd(0, 1, 0, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pf_lanectrl_dly_seq.md
# pf_lanectrl_dly_seq

Fabric-side sequencer that drives the DDR4 lane controller's delay-line control port from the FAB_CLK domain. It accepts tap-move and tap-reload commands for the RX or TX DQS delay line and wraps each one in an HS_IO_CLK_PAUSE window. It issues single-cycle DELAY_LINE_MOVE / DELAY_LINE_LOAD pulses with controlled spacing, tracks the current tap position of each line, and aborts when the lane reports out-of-range. It sits between the DDR training logic and each LANE_x_CTRL instance, one per lane.

## Interface
- TAP_MAX, 255: highest legal tap code (8-bit delay line).
- INIT_TAP, 1: tap value after reset and after a LOAD command; matches the lane's RX/TX_DQS_DELAY_VAL.
- PAUSE_LEAD, 2: cycles HS_IO_CLK_PAUSE is high before the first pulse (≥1).
- MOVE_GAP, 4: idle cycles after each pulse (≥2, covers the lane's pause synchronizer).
- PAUSE_TRAIL, 2: cycles HS_IO_CLK_PAUSE stays high after the last gap (≥1).

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE; a command is accepted on a cycle with VALID&READY.
- CMD_SEL  in  1  0 = RX DQS line, 1 = TX DQS line.
- CMD_DIR  in  1  1 = increment tap, 0 = decrement.
- CMD_LOAD  in  1  1 = reload line to INIT_TAP; CMD_DIR/CMD_COUNT ignored.
- CMD_COUNT  in  8  number of taps to move; 0 is legal.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller.
- DELAY_LINE_SEL, DELAY_LINE_DIRECTION  out  1 each  to the lane; registered, held stable for the whole pause window.
- DELAY_LINE_MOVE, DELAY_LINE_LOAD  out  1 each  single-cycle pulses to the lane.
- HS_IO_CLK_PAUSE  out  1  to the lane's pause synchronizer.
- RX_TAP, TX_TAP  out  8 each  tracked tap position.
- DONE  out  1  one-cycle completion pulse.
- OOR  out  1  valid with DONE: command aborted or saturated.
- MOVED  out  8  taps actually moved by the last command; valid from DONE until the next accept.

## Operation
- FSM states: IDLE, LEAD, PULSE, GAP, TRAIL, FIN.
- IDLE: on accept, latch SEL, DIR, LOAD and COUNT; clear MOVED and OOR; go to LEAD.
- LEAD: HS_IO_CLK_PAUSE=1 for PAUSE_LEAD cycles.
  - Go to PULSE if LOAD=1 or remaining count >0; otherwise go to TRAIL.
- PULSE (one cycle), load command: DELAY_LINE_LOAD=1; the selected tap is set to INIT_TAP; go to GAP, then TRAIL.
- PULSE (one cycle), move command:
  - Saturation check: if DIR=1 and tap==TAP_MAX, or DIR=0 and tap==0, no pulse is issued; set OOR; go to TRAIL.
  - Otherwise DELAY_LINE_MOVE=1; the tap moves ±1; MOVED+1; remaining count−1; go to GAP.
- GAP: MOVE_GAP cycles.
  - At the end of GAP, go to PULSE if remaining >0, else to TRAIL.
  - The selected line's OUT_OF_RANGE is sampled on every GAP cycle. If it is high: set OOR, skip the remaining moves, go to TRAIL. The tap already counted for the preceding pulse is kept.
- TRAIL: pause held high for PAUSE_TRAIL cycles; go to FIN.
- FIN (one cycle): HS_IO_CLK_PAUSE=0, DONE=1; next state IDLE.
- OUT_OF_RANGE inputs are ignored outside GAP. The unselected line's input is always ignored.
- Taps never wrap; arithmetic is 8-bit, bounded by saturation.

## Timing
- Reset values: CMD_READY=1 (IDLE); HS_IO_CLK_PAUSE, DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DONE, OOR = 0; MOVED=0; RX_TAP=TX_TAP=INIT_TAP.
- Reset mid-command: the next edge with RESET_N low forces all outputs to their reset values (pause drops immediately; no trail). Commands are ignored while RESET_N is low.
- Cycle numbering: accept edge = cycle 0.
  - Pause is high from cycle 1.
  - Move k pulses at cycle PAUSE_LEAD+1+(k−1)(MOVE_GAP+1).
  - After the last pulse at cycle m: GAP m+1..m+MOVE_GAP, TRAIL for the next PAUSE_TRAIL cycles, then FIN with DONE=1. IDLE (READY=1) follows on the next cycle.
- SEL and DIRECTION change only on the accept edge. They are stable ≥PAUSE_LEAD cycles before the first pulse.
- Tap outputs update on the edge ending the PULSE cycle.
- CMD_READY=0 from cycle 1 through FIN inclusive; back-to-back commands are separated by ≥1 IDLE cycle.

## Test plan
- Defaults, RX, DIR=1, COUNT=3 from tap 1 → MOVE pulses at cycles 3, 8, 13; pause high cycles 1–19; DONE at 20; RX_TAP=4, MOVED=3, OOR=0; TX_TAP unchanged.
- TX, COUNT=0 → no MOVE/LOAD pulse; pause high cycles 1–4; DONE at 5, MOVED=0, OOR=0.
- RX, DIR=0, COUNT=5 from tap 1 → 1 pulse (cycle 3); saturation at cycle 8 gives no pulse; DONE with RX_TAP=0, MOVED=1, OOR=1.
- TX, COUNT=10; TX_DELAY_LINE_OUT_OF_RANGE raised during the gap after pulse 2 → no further pulses; DONE with MOVED=2, OOR=1; RX_OUT_OF_RANGE toggling during the command has no effect.
- TX at tap 40, LOAD=1 → one DELAY_LINE_LOAD pulse at cycle 3, no MOVE; TX_TAP=1, DONE at 10.
- RESET_N low at cycle 9 of a COUNT=3 move → pause, MOVE and DONE all 0 next edge; taps=INIT_TAP; CMD_READY=1 once reset releases.
